// File: rtl/mlp_pkg.sv
// Shared widths, fixed weights/biases and FSM encoding for the sequential MLP classifier.
package mlp_pkg;
   localparam int IN_W  = 4;    // feature width
   localparam int H_W   = 11;   // hidden activation width
   localparam int O_W   = 18;   // output activation width
   localparam int W_W   = 8;    // signed weight width
   localparam int ACC_W = 20;   // accumulator / product width
   localparam int ACT_W = 12;   // zero-extended multiplier activation operand
   localparam int L0_SW = 12;   // significant sum bits, hidden layer
   localparam int L1_SW = 19;   // significant sum bits, output layer

   localparam int N_IN  = 4;    // hidden-layer fan-in
   localparam int N_HID = 3;    // output-layer fan-in
   localparam int N_CLS = 3;    // class count

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_L0   = 2'd1,
      ST_L1   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic signed [W_W-1:0] HID_W [N_HID][N_IN] = '{
      '{ 8'sd35,  8'sd35, -8'sd99,  8'sd37},
      '{ 8'sd16,  8'sd18, -8'sd32, -8'sd22},
      '{ 8'sd42,  8'sd44, -8'sd36, -8'sd52}
   };
   localparam logic signed [ACC_W-1:0] HID_B [N_HID] = '{-20'sd462, -20'sd55, 20'sd501};

   localparam logic signed [W_W-1:0] OUT_W [N_CLS][N_HID] = '{
      '{ 8'sd42, -8'sd22,  8'sd71},
      '{-8'sd30,  8'sd72, -8'sd49},
      '{ 8'sd6,  -8'sd31,  8'sd10}
   };
   localparam logic signed [ACC_W-1:0] OUT_B [N_CLS] = '{-20'sd33844, 20'sd29282, -20'sd108};
endpackage

// File: rtl/mlp_seq_engine_if.sv
// Sample-in / decision-out handshake bundle for mlp_seq_engine.
interface mlp_seq_engine_if #(
   parameter int IN_W = mlp_pkg::IN_W,
   parameter int O_W  = mlp_pkg::O_W
);
   logic              in_valid;
   logic              in_ready;
   logic [4*IN_W-1:0] inp;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out;
   logic [3*O_W-1:0]  predo;

   // engine side
   modport slave (
      input  in_valid, inp, out_ready,
      output in_ready, out_valid, out, predo
   );
   // producer/consumer side
   modport master (
      output in_valid, inp, out_ready,
      input  in_ready, out_valid, out, predo
   );
endinterface

// File: rtl/mlp_mac_unit.sv
// Shared multiply-accumulate with bias load and per-layer ReLU/truncate of the running sum.
module mlp_mac_unit
   import mlp_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,      // one MAC this cycle
   input  logic                    load,    // first term of a neuron: start from bias
   input  logic                    layer,   // 0: hidden (12-bit sum), 1: output (19-bit sum)
   input  logic [ACT_W-1:0]        act,
   input  logic signed [W_W-1:0]   weight,
   input  logic signed [ACC_W-1:0] bias,
   output logic [O_W-1:0]          relu     // committed activation if this is the last term
);
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] sum;
   logic [L0_SW-1:0]        s0;
   logic [L1_SW-1:0]        s1;

   // product, next sum, and ReLU of the low bits; wrap above those bits is intended
   always_comb begin
      prod = ACC_W'($signed({1'b0, act})) * ACC_W'(weight);
      sum  = (load ? bias : acc) + prod;
      s0   = sum[L0_SW-1:0];
      s1   = sum[L1_SW-1:0];
      if (layer) relu = s1[L1_SW-1] ? '0 : s1[O_W-1:0];
      else       relu = s0[L0_SW-1] ? '0 : O_W'(s0[H_W-1:0]);
   end

   // accumulator advances only on MAC cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  acc <= '0;
      else if (en) acc <= sum;
   end
endmodule

// File: rtl/mlp_seq_engine.sv
// 4-11-18 three-class MLP, one MAC time-shared over all 21 products, argmax on the fly.
module mlp_seq_engine #(
   parameter int IN_W = mlp_pkg::IN_W,
   parameter int H_W  = mlp_pkg::H_W,
   parameter int O_W  = mlp_pkg::O_W,
   parameter int W_W  = mlp_pkg::W_W
) (
   input  logic               clk,
   input  logic               rst_n,
   mlp_seq_engine_if.slave    bus
);
   import mlp_pkg::*;

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] L0   = ST_L0;
   localparam logic [1:0] L1   = ST_L1;
   localparam logic [1:0] DONE = ST_DONE;

   logic [1:0]              state, n, k;
   logic [4*IN_W-1:0]       x;
   logic [H_W-1:0]          hid  [N_HID];
   logic [O_W-1:0]          ores [N_CLS];
   logic [O_W-1:0]          best;
   logic [1:0]              best_idx;
   logic [ACT_W-1:0]        act;
   logic signed [W_W-1:0]   wgt;
   logic signed [ACC_W-1:0] bias;
   logic                    busy, last, layer;
   logic [O_W-1:0]          relu;

   // operand select for the shared MAC: features in L0, hidden activations in L1
   always_comb begin
      layer = (state == L1);
      busy  = (state == L0) || (state == L1);
      act   = '0;
      wgt   = '0;
      bias  = '0;
      last  = 1'b0;
      if (state == L0) begin
         act  = ACT_W'(x[k*IN_W +: IN_W]);
         wgt  = HID_W[n][k];
         bias = HID_B[n];
         last = (k == 2'd3);
      end else if (state == L1) begin
         act  = ACT_W'(hid[k]);
         wgt  = OUT_W[n][k];
         bias = OUT_B[n];
         last = (k == 2'd2);
      end
   end

   mlp_mac_unit u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (busy),
      .load   (k == 2'd0),
      .layer  (layer),
      .act    (act),
      .weight (wgt),
      .bias   (bias),
      .relu   (relu)
   );

   // sequencer: capture, walk neurons/terms, commit activations and running argmax
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         n        <= '0;
         k        <= '0;
         x        <= '0;
         best     <= '0;
         best_idx <= '0;
         for (int i = 0; i < N_HID; i++) hid[i]  <= '0;
         for (int i = 0; i < N_CLS; i++) ores[i] <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               x     <= bus.inp;
               n     <= '0;
               k     <= '0;
               state <= L0;
            end
            L0, L1: if (last) begin
               k <= '0;
               if (state == L0) hid[n] <= relu[H_W-1:0];
               else begin
                  ores[n] <= relu;
                  // strict compare: a tie keeps the lower class index
                  if (n == 2'd0 || relu > best) begin
                     best     <= relu;
                     best_idx <= n;
                  end
               end
               if (n == 2'd2) begin
                  n     <= '0;
                  state <= (state == L0) ? L1 : DONE;
               end else begin
                  n <= n + 2'd1;
               end
            end else begin
               k <= k + 2'd1;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && rst_n;
   assign bus.out_valid = (state == DONE);
   assign bus.out       = best_idx;
   assign bus.predo     = {ores[0], ores[1], ores[2]};
endmodule

// File: doc/mlp_seq_engine.md
# mlp_seq_engine

Sequential, resource-shared implementation of the 4-11-18 three-class MLP classifier (4 unsigned 4-bit features, 3 ReLU hidden neurons, 3 ReLU output neurons, argmax). One signed multiplier and one accumulator are time-multiplexed across all 21 weight products under an FSM. Results are bit-exact with the fully parallel classifier. The block sits between the sensor front-end, which is the valid/ready producer, and the decision consumer.

## Interface
Parameters:
- IN_W, 4: per-feature width; 4 features are packed into `inp`.
- H_W, 11: hidden activation width.
- O_W, 18: output activation width.
- W_W, 8: signed weight width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  `inp` is valid.
- in_ready  out  1  block accepts a sample; high only in IDLE.
- inp  in  16  features: f0=inp[3:0], f1=[7:4], f2=[11:8], f3=[15:12].
- out_valid  out  1  `out` and `predo` are valid.
- out_ready  in  1  consumer accepts the result.
- out  out  2  predicted class, 0..2.
- predo  out  54  {o0,o1,o2}, each 18 bits unsigned.

## Operation
- Fixed constants:
  - Hidden weights: h0=[35,35,-99,37], h1=[16,18,-32,-22], h2=[42,44,-36,-52].
  - Hidden biases: [-462,-55,501].
  - Output weights: o0=[42,-22,71], o1=[-30,72,-49], o2=[6,-31,10].
  - Output biases: [-33844,29282,-108].
- FSM states: IDLE, L0, L1, DONE.
  - IDLE: in_ready=1. When in_valid is high, register inp, clear neuron index n and term index k, and go to L0.
  - L0: one product per cycle, inp feature k × weight h[n][k]. When k=0, the accumulator loads bias+product; otherwise it adds the product.
  - L0 neuron commit (k=3): compute s = (acc+prod)[11:0] as signed. Store hidden[n] = s<0 ? 0 : s[10:0]. Then n++ and k=0. After n=2, go to L1.
  - L1: the same scheme over the 3 hidden values, each zero-extended to 12 bits signed. Sum is 19-bit signed; o[n] = s<0 ? 0 : s[17:0].
  - On each L1 commit the running argmax updates. o0 is taken unconditionally. For n>0, the new index replaces the held one only if o[n] > best (strict). Ties therefore keep the lower index, matching a chain of >= comparators. After n=2, go to DONE.
  - DONE: out_valid=1 and out/predo held stable. On out_ready, go to IDLE.
- Arithmetic: the accumulator is at least 20 bits signed. Only the low 12 (L0) or 19 (L1) bits define the sum; wrap-around is intended, not an error. The multiplier operand is a 12-bit zero-extended activation × 8-bit signed weight.
- Reset, including mid-computation: state returns to IDLE and n, k, and the accumulator are cleared. in_ready=0 while rst_n is low and 1 after release. out_valid=0, out=0, predo=0. Any partial result is discarded.
- in_valid outside IDLE is ignored; the sample is not captured.

## Timing
- The accept edge is edge 0.
- L0 MACs occupy edges 1–12 and L1 MACs occupy edges 13–21.
- out_valid goes high after edge 21, giving a latency of 21 cycles.
- The output handshake completes on the edge where out_valid && out_ready. in_ready is high the following cycle.
- Maximum throughput is one sample per 23 cycles, with out_ready tied high.
- out and predo change only on L1 commits and reset. They stay stable for the whole time out_valid is high, even while out_ready is low indefinitely.

## Structure
- Package mlp_pkg holds:
  - width localparams;
  - weight and bias constant arrays (signed);
  - the FSM state enum;
  - the fan-in counts (4, 3) and class count (3).
- Sub-module mlp_mac_unit: multiplier, accumulator with bias-load/accumulate select, and ReLU/truncate commit logic with a layer-select input. The FSM, activation registers and argmax stay in mlp_seq_engine.

## Test plan
- inp=16'h0000 → after 21 cycles: predo={1727,4733,4902}, out=2; hidden = {0,0,501}.
- inp=16'hFFFF → predo={0,6203,4602}, out=1; hidden = {0,0,471}.
- Hold out_ready=0 for 50 cycles in DONE → out, predo and out_valid stable; in_ready=0; in_valid pulses ignored. Then out_ready=1 → in_ready=1 next cycle.
- Back-to-back 0x0000 then 0xFFFF with out_ready=1 → two results, 23 cycles apart, values as above.
- Assert rst_n=0 at edge 10 (mid-L0), then release and send 0xFFFF → all outputs 0 during reset; the following result is correct (out=1) with no stale data.
- Random 1000 samples vs. a golden model of the parallel classifier, including 12-bit/19-bit wrap and the tie rule → exact match on out and predo.
